// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(mem_size_t size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of assembled load data by access size
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_data,
  input  mem_size_t   size,
  input  logic        sign,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (size)
      BYTE:    ext_data = {{24{sign & raw_data[7]}}, raw_data[7:0]};
      HALF:    ext_data = {{16{sign & raw_data[15]}}, raw_data[15:0]};
      default: ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial data-memory initiator for core loads/stores
// Optional MISALIGN_TRAP_EN: misaligned half/word requests get an error response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STORE_WIDTH   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_sign_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [STORE_WIDTH-1:0]   mem_wdata_o,
  input  logic [STORE_WIDTH-1:0]   mem_rdata_i,
  output logic                     resp_valid_o,
  output logic [DATA_WIDTH-1:0]    resp_rdata_o,
  output logic                     resp_error_o
);

  lsu_state_t state;
  logic       write_q;
  logic       sign_q;
  mem_size_t  size_q;
  logic [1:0] cnt_q;
  logic [23:0] wdata_q;
  logic [23:0] asm_q;

  mem_size_t   req_size;
  logic        req_bad;
  logic [31:0] wdata_aligned;
  logic [31:0] asm_shift;
  logic [31:0] load_ext;
  logic [1:0]  last_idx;

  assign req_size    = mem_size_t'(req_size_i);
  assign req_ready_o = (state == IDLE) && !rst_i;
  assign asm_shift   = {asm_q, mem_rdata_i};
  assign last_idx    = 2'(size_bytes(size_q) - 3'd1);

  // Store data is left-aligned so the first byte issued is always bits [31:24].
  always_comb begin
    wdata_aligned = req_wdata_i[31:0];
    case (req_size)
      BYTE:    wdata_aligned = {req_wdata_i[7:0], 24'h0};
      HALF:    wdata_aligned = {req_wdata_i[15:0], 16'h0};
      default: wdata_aligned = req_wdata_i[31:0];
    endcase
  end

  always_comb begin
    req_bad = (req_size == RSVD);
`ifdef MISALIGN_TRAP_EN
    if (req_size == HALF && req_addr_i[0]) req_bad = 1'b1;
    if (req_size == WORD && req_addr_i[1:0] != 2'b00) req_bad = 1'b1;
`endif
  end

  lsu_load_extend u_load_extend (
    .raw_data (asm_shift),
    .size     (size_q),
    .sign     (sign_q),
    .ext_data (load_ext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= BYTE;
      cnt_q        <= 2'd0;
      wdata_q      <= '0;
      asm_q        <= '0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_error_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            sign_q  <= req_sign_i;
            size_q  <= req_size;
            cnt_q   <= 2'd0;
            asm_q   <= '0;
            if (req_bad) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_error_o <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state       <= ISSUE;
              mem_en_o    <= 1'b1;
              mem_we_o    <= req_write_i;
              mem_addr_o  <= req_addr_i;
              mem_wdata_o <= req_write_i ? wdata_aligned[31:24] : '0;
              wdata_q     <= wdata_aligned[23:0];
            end
          end
        end

        ISSUE: begin
          // Read data lags its access by one cycle, so capture starts with the second issue cycle.
          if (!write_q && cnt_q != 2'd0) asm_q <= asm_shift[23:0];
          if (cnt_q == last_idx) begin
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            if (write_q) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt_q       <= cnt_q + 2'd1;
            mem_addr_o  <= mem_addr_o + ADDRESS_WIDTH'(1);
            mem_wdata_o <= write_q ? wdata_q[23:16] : '0;
            wdata_q     <= {wdata_q[15:0], 8'h0};
          end
        end

        DRAIN: begin
          asm_q        <= asm_shift[23:0];
          resp_rdata_o <= load_ext;
          resp_valid_o <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          resp_valid_o <= 1'b0;
          resp_error_o <= 1'b0;
          resp_rdata_o <= '0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-memory model
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  load_store_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_size_i   (req_size),
    .req_sign_i   (req_sign),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_error_o (resp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte memory seen by the DUT
  logic [7:0] dmem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) dmem[mem_addr] = mem_wdata;
      else mem_rdata <= dmem.exists(mem_addr) ? dmem[mem_addr] : 8'h00;
    end
  end

  // Reference memory image maintained by the model
  logic [7:0] ref_mem [logic [31:0]];

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [7:0] data; } mem_exp_t;
  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_exp_t;
  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'h00;
  endfunction

  // Expected memory traffic and response for a request accepted at the end of cycle c0
  task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input int c0, output int lat);
    int n;
    longint v;
    logic err;
    logic [31:0] ba;
    logic [7:0] b;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) err = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) err = 1'b1;
`endif
    if (err) begin
      rsp_q.push_back('{c0 + 1, 32'h0, 1'b1});
      lat = 1;
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      if (w) begin
        b = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        ref_mem[ba] = b;
        mem_q.push_back('{c0 + 1 + i, 1'b1, ba, b});
      end else begin
        v = v * 256 + longint'(ref_rd(ba));
        mem_q.push_back('{c0 + 1 + i, 1'b0, ba, 8'h00});
      end
    end
    if (w) begin
      rsp_q.push_back('{c0 + n + 1, 32'h0, 1'b0});
      lat = n + 1;
    end else begin
      if (sg && v >= (longint'(1) << (8 * n - 1)))
        v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
      rsp_q.push_back('{c0 + n + 2, 32'(v), 1'b0});
      lat = n + 2;
    end
  endtask

  // Monitor: every memory access and response is matched against the scoreboard
  always @(negedge clk) begin
    mem_exp_t me;
    rsp_exp_t re;
    if (mon_on) begin
      if (mem_en !== 1'b0) begin
        if (mem_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_mem_access: got addr %h we %b at cycle %0d, expected no access", mem_addr, mem_we, cyc);
        end else begin
          me = mem_q.pop_front();
          chk("mem_cycle", 32'(cyc), 32'(me.cyc));
          chk("mem_we", {31'h0, mem_we}, {31'h0, me.we});
          chk("mem_addr", mem_addr, me.addr);
          if (me.we) chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, me.data});
        end
      end
      if (resp_valid !== 1'b0) begin
        if (rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_resp: got rdata %h err %b at cycle %0d, expected no response", resp_rdata, resp_error, cyc);
        end else begin
          re = rsp_q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(re.cyc));
          chk("resp_rdata", resp_rdata, re.rdata);
          chk("resp_error", {31'h0, resp_error}, {31'h0, re.err});
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    int lat;
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got req_ready %b, expected 1 within 20 cycles", req_ready);
      return;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
    model(w, sz, sg, a, wd, cyc, lat);
    // Scramble request inputs while busy; they must be ignored.
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      req_valid = (i == lat) ? 1'b0 : 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_sign  = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    @(posedge clk); #1;
    chk("ready_after_resp", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] a;
    int r;
    logic [1:0] sz;

    repeat (3) begin @(posedge clk); #1; end
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_mem_en", {30'h0, mem_en, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h101, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h81020304);
    do_req(1'b0, 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h110, 32'hAAAA8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h110, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h111, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h120, 32'h123456F0);
    do_req(1'b0, 2'd0, 1'b1, 32'h120, 32'h0);

    for (int k = 0; k < 150; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h100 + 32'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset during a word store: only the first byte lands
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hAABBCCDD);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h11223344;
    c0 = cyc;
    mem_q.push_back('{c0 + 1, 1'b1, 32'h200, 8'h11});
    ref_mem[32'h200] = 8'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
    chk("abort_ready_in_rst", {31'h0, req_ready}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++)
      chk("abort_mem_byte", {24'h0, dmem_rd(32'h200 + 32'(i))}, {24'h0, ref_rd(32'h200 + 32'(i))});
    repeat (3) begin @(posedge clk); #1; end
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);

    repeat (5) begin @(posedge clk); #1; end
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
